// File: rtl/fifo_pendbuffer.sv
// Single-write-port FIFO whose pops clear the head entry; pushes that lose the
// write port to a pop (or queue behind earlier deferred pushes) wait in a small pending queue.
module fifo_pendbuffer #(
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int PEND      = 2,
    parameter int AF_THRESH = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          write,
    input  logic [DW-1:0] wr_data,
    input  logic          read,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic [2:0]    pend_cnt,
    output logic          overflow,
    output logic          underflow,
    input  logic          clear_err
);

    localparam int DEPTH = 1 << AW;
    localparam int SW    = AW + 2;

    logic [DW-1:0] mem [DEPTH];

    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [2:0]    pend_cnt_q, pend_cnt_d;
    logic [DW-1:0] pend_q [PEND];
    logic [DW-1:0] pend_d [PEND];
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic [SW-1:0] occ;
    logic          pend_nonempty;
    logic          pop, push, drain, direct, enq, commit;
    logic [2:0]    enq_idx;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    // Pending entries count as occupancy so a deferred push always finds room later.
    assign occ           = SW'(count_q) + SW'(pend_cnt_q);
    assign pend_nonempty = (pend_cnt_q != 3'd0);

    assign full        = (occ == SW'(DEPTH)) || (pend_cnt_q == 3'(PEND));
    assign empty       = (count_q == '0);
    assign almost_full = (occ >= SW'(AF_THRESH));
    assign count       = count_q;
    assign pend_cnt    = pend_cnt_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign rd_data     = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    assign pop    = read && !empty;
    assign push   = write && !full;
    assign drain  = !pop && pend_nonempty;
    assign direct = push && !pop && !pend_nonempty;
    assign enq    = push && (pop || pend_nonempty);
    assign commit = drain || direct;

    // A same-cycle drain shifts the queue down first, so the new tail lands one slot lower.
    assign enq_idx = pend_cnt_q - {2'b00, drain};

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q[AW-1:0];
        mem_wdata = wr_data;
        if (pop) begin
            mem_we    = 1'b1;
            mem_waddr = rd_ptr_q[AW-1:0];
            mem_wdata = '0;
        end else if (pend_nonempty) begin
            mem_we    = 1'b1;
            mem_wdata = pend_q[0];
        end else if (push) begin
            mem_we    = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < PEND; gi++) begin : g_pend_slot
            logic [DW-1:0] shifted;
            if (gi < PEND - 1) begin : g_mid
                assign shifted = drain ? pend_q[gi+1] : pend_q[gi];
            end else begin : g_last
                assign shifted = pend_q[gi];
            end
            assign pend_d[gi] = (enq && (enq_idx == 3'(gi))) ? wr_data : shifted;
        end
    endgenerate

    assign pend_cnt_d  = pend_cnt_q + {2'b00, enq} - {2'b00, drain};
    assign count_d     = count_q + {{AW{1'b0}}, commit} - {{AW{1'b0}}, pop};
    assign rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    assign wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, commit};
    assign overflow_d  = (overflow_q && !clear_err) || (write && full);
    assign underflow_d = (underflow_q && !clear_err) || (read && empty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            pend_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < PEND; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pend_cnt_q  <= pend_cnt_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            for (int i = 0; i < PEND; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    // Contents are not reset, but no write may land on an edge where reset is held.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
